// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one pipelined Wishbone slave port
// among NUM_MASTERS masters. A master keeps the bus for its whole cycle (cyc).
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the per-tenure watchdog
// (TIMEOUT_CYCLES) that aborts a cycle whose strobes are never acked.
//
// Ports (master i uses slice [i*W +: W] of each flattened vector):
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i       per-master cycle, strobe, write enable
//   m_adr_i/m_dat_i/m_sel_i      per-master address, write data, byte selects
//   m_tagn_i                     per-master tag
//   m_dat_o                      slave read data broadcast to all masters
//   m_ack_o/m_stall_o/m_tagn_o   per-master handshakes (granted bit only)
//   m_timeout_o                  one-cycle watchdog pulse (0 without macro)
//   s_*_o                        muxed request towards the slave
//   s_dat_i/s_ack_i/s_stall_i/s_tagn_i  slave response
//   grant_o                      one-hot current grant
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NUM_MASTERS-1:0]                  m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                  m_stb_i,
  input  logic [NUM_MASTERS-1:0]                  m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]       m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]       m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]                  m_tagn_i,
  output logic [DATA_WIDTH-1:0]                   m_dat_o,
  output logic [NUM_MASTERS-1:0]                  m_ack_o,
  output logic [NUM_MASTERS-1:0]                  m_stall_o,
  output logic [NUM_MASTERS-1:0]                  m_tagn_o,
  output logic [NUM_MASTERS-1:0]                  m_timeout_o,
  output logic                                    s_cyc_o,
  output logic                                    s_stb_o,
  output logic                                    s_we_o,
  output logic [ADDR_WIDTH-1:0]                   s_adr_o,
  output logic [DATA_WIDTH-1:0]                   s_dat_o,
  output logic [DATA_WIDTH/8-1:0]                 s_sel_o,
  output logic                                    s_tagn_o,
  input  logic [DATA_WIDTH-1:0]                   s_dat_i,
  input  logic                                    s_ack_i,
  input  logic                                    s_stall_i,
  input  logic                                    s_tagn_i,
  output logic [NUM_MASTERS-1:0]                  grant_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_arbiter: parameter out of range");
  end

  logic [0:0]             state;
  logic [NUM_MASTERS-1:0] grant;
  logic [LW-1:0]          last;
  logic [NUM_MASTERS-1:0] req;
  logic                   found;
  logic [LW-1:0]          pick;
  logic                   timeout;

  logic                   sel_cyc, sel_stb, sel_we, sel_tag;
  logic [ADDR_WIDTH-1:0]  sel_adr;
  logic [DATA_WIDTH-1:0]  sel_dat;
  logic [SW-1:0]          sel_sel;

  // (base + off) mod NUM_MASTERS, for the round-robin search order
  function automatic logic [LW-1:0] next_idx(input logic [LW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return LW'(s % 32'(NUM_MASTERS));
  endfunction

  // First eligible requester after the most recent grantee, wrapping
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      if (!found && req[next_idx(last, k)]) begin
        found = 1'b1;
        pick  = next_idx(last, k);
      end
    end
  end

  // One-hot AND-OR mux; everything reads 0 while nobody holds the grant
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_tag = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        sel_cyc = m_cyc_i[i];
        sel_stb = m_stb_i[i];
        sel_we  = m_we_i[i];
        sel_tag = m_tagn_i[i];
        sel_adr = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_sel = m_sel_i[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= NUM_MASTERS'(1) << pick;
            last  <= pick;
            state <= BUSY;
          end else begin
            grant <= '0;
          end
        end
        BUSY: begin
          if (!sel_cyc || timeout) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]          to_cnt;
  logic [7:0]             outstanding;
  logic [NUM_MASTERS-1:0] blocked;
  logic                   accept;
  logic                   ack_dec;

  assign accept  = s_stb_o & ~s_stall_i;
  assign ack_dec = s_ack_i & (outstanding != '0);
  assign timeout = (state == BUSY) && (to_cnt >= CW'(TIMEOUT_CYCLES));
  // A timed-out master stays ineligible until it drops cyc
  assign req     = m_cyc_i & ~blocked;
  assign m_timeout_o = timeout ? grant : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt      <= '0;
      outstanding <= '0;
      blocked     <= '0;
    end else begin
      blocked <= (blocked & m_cyc_i) | (timeout ? grant : '0);
      if (state == IDLE || timeout) begin
        to_cnt      <= '0;
        outstanding <= '0;
      end else begin
        outstanding <= outstanding + {7'b0, accept} - {7'b0, ack_dec};
        // The accepting cycle already counts, so the pulse lands
        // TIMEOUT_CYCLES cycles after the unacked strobe was taken.
        if (s_ack_i)
          to_cnt <= '0;
        else if (accept || outstanding != '0)
          to_cnt <= to_cnt + CW'(1);
      end
    end
  end
`else
  assign timeout     = 1'b0;
  assign req         = m_cyc_i;
  assign m_timeout_o = '0;
`endif

  assign s_cyc_o   = sel_cyc & ~timeout;
  assign s_stb_o   = s_cyc_o & sel_stb;
  assign s_we_o    = sel_we;
  assign s_adr_o   = sel_adr;
  assign s_dat_o   = sel_dat;
  assign s_sel_o   = sel_sel;
  assign s_tagn_o  = sel_tag;

  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = grant & {NUM_MASTERS{s_ack_i}};
  assign m_stall_o = ~grant | {NUM_MASTERS{s_stall_i}};
  assign m_tagn_o  = grant & {NUM_MASTERS{s_tagn_i}};
  assign grant_o   = grant;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter with four masters.
module tb_wb_arbiter;

  localparam int NM = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i, m_tagn_i;
  logic [NM*32-1:0]  m_adr_i, m_dat_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_stall_o, m_tagn_o, m_timeout_o, grant_o;
  logic              s_cyc_o, s_stb_o, s_we_o, s_tagn_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i, s_stall_i, s_tagn_i;

  logic        cyc_r[NM], stb_r[NM], we_r[NM], tag_r[NM];
  logic [31:0] adr_r[NM], dat_r[NM];
  logic [3:0]  sel_r[NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_cyc_i[i]  = cyc_r[i];
      m_stb_i[i]  = stb_r[i];
      m_we_i[i]   = we_r[i];
      m_tagn_i[i] = tag_r[i];
      m_adr_i[i*32 +: 32] = adr_r[i];
      m_dat_i[i*32 +: 32] = dat_r[i];
      m_sel_i[i*4 +: 4]   = sel_r[i];
    end
  end

  wb_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_tagn_i(m_tagn_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_stall_o(m_stall_o),
    .m_tagn_o(m_tagn_o), .m_timeout_o(m_timeout_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_tagn_o(s_tagn_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i), .s_tagn_i(s_tagn_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // Slave model: acks each accepted strobe two cycles later with adr ^ 5A5A0000
  logic        ack_en;
  logic        acc_s, rst_s, d1, d2;
  logic [31:0] acc_a, a1, a2;
  initial begin
    d1 = 1'b0; d2 = 1'b0; a1 = '0; a2 = '0;
    acc_s = 1'b0; rst_s = 1'b1; acc_a = '0;
    s_ack_i = 1'b0; s_dat_i = '0; s_tagn_i = 1'b0;
  end
  always @(negedge clk) begin
    acc_s = s_stb_o & ~s_stall_i & ~rst_i & ack_en;
    acc_a = s_adr_o;
    rst_s = rst_i;
  end
  always @(posedge clk) begin
    #1;
    if (rst_s) begin
      d1 = 1'b0; d2 = 1'b0;
    end else begin
      d2 = d1; a2 = a1;
      d1 = acc_s; a1 = acc_a;
    end
    s_ack_i = d2;
    s_dat_i = a2 ^ 32'h5A5A_0000;
  end

  typedef struct packed {
    logic [31:0] adr; logic [31:0] dat; logic we; logic [3:0] sel; logic tag;
  } bus_t;
  typedef struct packed { logic [NM-1:0] vec; logic [31:0] dat; } ack_t;

  bus_t          exp_bus[$];
  ack_t          exp_ack[$];
  logic [NM-1:0] exp_grant[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [NM-1:0] prev_g;
    int zero_run;
    bus_t b;
    ack_t a;
    prev_g = '0;
    zero_run = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_g = '0;
        zero_run = 0;
      end else begin
        check((m_stall_o | grant_o) == '1, "stall_mask", 64'(m_stall_o | grant_o), 64'hF);
        check((m_ack_o & ~grant_o) == '0, "ack_mask", 64'(m_ack_o), 64'(grant_o));
`ifdef WB_ARB_TIMEOUT_EN
        check((m_timeout_o & ~grant_o) == '0, "timeout_mask", 64'(m_timeout_o), 64'(grant_o));
`else
        check(m_timeout_o == '0, "timeout_zero", 64'(m_timeout_o), 64'h0);
`endif
        if (|m_ack_o) begin
          if (exp_ack.size() == 0) check(1'b0, "ack_unexpected", 64'(m_ack_o), 64'h0);
          else begin
            a = exp_ack.pop_front();
            check(m_ack_o == a.vec, "ack_vec", 64'(m_ack_o), 64'(a.vec));
            check(m_dat_o == a.dat, "ack_dat", 64'(m_dat_o), 64'(a.dat));
          end
        end
        if (s_stb_o && !s_stall_i) begin
          if (exp_bus.size() == 0) check(1'b0, "bus_unexpected", 64'(s_adr_o), 64'h0);
          else begin
            b = exp_bus.pop_front();
            check(s_adr_o == b.adr, "bus_adr", 64'(s_adr_o), 64'(b.adr));
            check(s_dat_o == b.dat, "bus_dat", 64'(s_dat_o), 64'(b.dat));
            check({s_we_o, s_sel_o, s_tagn_o} == {b.we, b.sel, b.tag}, "bus_ctl",
                  64'({s_we_o, s_sel_o, s_tagn_o}), 64'({b.we, b.sel, b.tag}));
          end
        end
        if (grant_o != '0 && grant_o != prev_g) begin
          if (exp_grant.size() == 0) check(1'b0, "grant_unexpected", 64'(grant_o), 64'h0);
          else begin
            logic [NM-1:0] g;
            g = exp_grant.pop_front();
            check(grant_o == g, "grant_seq", 64'(grant_o), 64'(g));
          end
          // exactly one cycle of grant==0 with a pending request before any new owner
          check(zero_run == 1, "idle_gap", 64'(zero_run), 64'd1);
        end
        if (grant_o != '0) zero_run = 0;
        else if (|m_cyc_i) zero_run++;
        else zero_run = 0;
        prev_g = grant_o;
      end
    end
  endtask

  // Pipelined master: n beats from base, holds each stb until not stalled
  task automatic master_run(input int m, input int n, input logic [31:0] base,
                            input logic w, input logic [31:0] wd, input logic [3:0] sel);
    int issued, acked, budget;
    bit pres, accepted;
    logic [31:0] a;
    issued = 0; acked = 0; budget = 400; pres = 0; accepted = 0;
    @(posedge clk); #1;
    cyc_r[m] = 1'b1;
    do begin
      @(negedge clk);
      budget--;
    end while (!grant_o[m] && budget > 0);
    while (acked < n && budget > 0) begin
      @(posedge clk); #1;
      if (pres && accepted) begin
        issued++;
        pres = 0;
      end
      if (issued < n) begin
        if (!pres) begin
          a = base + 32'(4 * issued);
          stb_r[m] = 1'b1; adr_r[m] = a; we_r[m] = w; dat_r[m] = wd; sel_r[m] = sel;
          exp_bus.push_back('{adr: a, dat: wd, we: w, sel: sel, tag: tag_r[m]});
          exp_ack.push_back('{vec: NM'(1 << m), dat: a ^ 32'h5A5A_0000});
          pres = 1;
        end
      end else begin
        stb_r[m] = 1'b0;
      end
      @(negedge clk);
      budget--;
      if (m_ack_o[m]) acked++;
      accepted = pres && !m_stall_o[m];
    end
    if (budget <= 0) check(1'b0, "master_budget", 64'(acked), 64'(n));
    @(posedge clk); #1;
    cyc_r[m] = 1'b0;
    stb_r[m] = 1'b0;
  endtask

  task automatic wait_grant(input int m);
    int budget;
    budget = 100;
    do begin
      @(negedge clk);
      budget--;
    end while (!grant_o[m] && budget > 0);
    if (!grant_o[m]) check(1'b0, "grant_wait", 64'(grant_o), 64'(1 << m));
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    bit seen;
    rst_i = 1'b1; s_stall_i = 1'b0; ack_en = 1'b1;
    for (int i = 0; i < NM; i++) begin
      cyc_r[i] = 1'b0; stb_r[i] = 1'b0; we_r[i] = 1'b0; tag_r[i] = i[0];
      adr_r[i] = '0; dat_r[i] = '0; sel_r[i] = '0;
    end
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(grant_o == '0, "rst_grant", 64'(grant_o), 64'h0);
    check({s_cyc_o, s_stb_o, s_we_o, s_tagn_o} == '0, "rst_s_ctl",
          64'({s_cyc_o, s_stb_o, s_we_o, s_tagn_o}), 64'h0);
    check(s_adr_o == '0 && s_sel_o == '0, "rst_s_adr", 64'(s_adr_o), 64'h0);
    check(m_stall_o == '1, "rst_stall", 64'(m_stall_o), 64'hF);
    check(m_ack_o == '0 && m_tagn_o == '0 && m_timeout_o == '0, "rst_ack",
          64'({m_ack_o, m_tagn_o, m_timeout_o}), 64'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // simultaneous request from 0 and 1 after reset: 0 first, then 1
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0010);
    fork
      master_run(0, 2, 32'h0000_0040, 1'b0, 32'h0, 4'hF);
      master_run(1, 1, 32'h0000_0080, 1'b0, 32'h0, 4'hF);
    join

    // single master 1, pipelined 4-beat read 0x100..0x10C
    exp_grant.push_back(4'b0010);
    master_run(1, 4, 32'h0000_0100, 1'b0, 32'h0, 4'hF);

    // write held off by three stall cycles: accepted exactly once
    @(posedge clk); #1;
    s_stall_i = 1'b1;
    exp_grant.push_back(4'b0001);
    fork
      master_run(0, 1, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 4'hF);
      begin
        int b;
        b = 100;
        do begin
          @(negedge clk);
          b--;
        end while (!s_stb_o && b > 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        s_stall_i = 1'b0;
      end
    join

    // four masters contending: 0,1,2,3,0
    reset_pulse();
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    fork
      begin
        master_run(0, 1, 32'h0000_1000, 1'b0, 32'h0, 4'hF);
        master_run(0, 1, 32'h0000_1004, 1'b0, 32'h0, 4'hF);
      end
      master_run(1, 1, 32'h0000_2000, 1'b1, 32'h1111_2222, 4'h3);
      master_run(2, 1, 32'h0000_3000, 1'b0, 32'h0, 4'hC);
      master_run(3, 1, 32'h0000_4000, 1'b1, 32'h3333_4444, 4'h1);
    join

    // reset while master 2 is mid-burst, master 0 waiting
    @(posedge clk); #1;
    ack_en = 1'b0;
    exp_grant.push_back(4'b0100);
    cyc_r[2] = 1'b1;
    wait_grant(2);
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      stb_r[2] = 1'b1; we_r[2] = 1'b0; dat_r[2] = '0; sel_r[2] = 4'hF;
      adr_r[2] = 32'h300 + 32'(4 * b);
      exp_bus.push_back('{adr: adr_r[2], dat: 32'h0, we: 1'b0, sel: 4'hF, tag: tag_r[2]});
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst_i = 1'b1; stb_r[2] = 1'b0; cyc_r[0] = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_grant.push_back(4'b0001);
    @(negedge clk);
    check(s_cyc_o == 1'b0, "rst_mid_cyc", 64'(s_cyc_o), 64'h0);
    check(grant_o == '0, "rst_mid_grant", 64'(grant_o), 64'h0);
    wait_grant(0);
    @(posedge clk); #1;
    cyc_r[0] = 1'b0; cyc_r[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ack_en = 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
    // slave never acks: pulse 16 cycles after acceptance, then master 3 gets the bus
    ack_en = 1'b0;
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b1000);
    cyc_r[1] = 1'b1; cyc_r[3] = 1'b1;
    wait_grant(1);
    @(posedge clk); #1;
    stb_r[1] = 1'b1; adr_r[1] = 32'h400; we_r[1] = 1'b0; dat_r[1] = '0; sel_r[1] = 4'hF;
    exp_bus.push_back('{adr: 32'h400, dat: 32'h0, we: 1'b0, sel: 4'hF, tag: tag_r[1]});
    @(negedge clk);
    @(posedge clk); #1;
    stb_r[1] = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (m_timeout_o != '0) begin
        seen = 1;
        check(m_timeout_o == 4'b0010, "timeout_vec", 64'(m_timeout_o), 64'h2);
        check(n == 16, "timeout_cycle", 64'(n), 64'd16);
        check(s_cyc_o == 1'b0, "timeout_cyc", 64'(s_cyc_o), 64'h0);
      end
    end
    if (!seen) check(1'b0, "timeout_missing", 64'(n), 64'd16);
    @(posedge clk); #1;
    cyc_r[1] = 1'b0;
    wait_grant(3);
    @(posedge clk); #1;
    cyc_r[3] = 1'b0;
    ack_en = 1'b1;
`else
    n = 0; seen = 0;
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    check(exp_bus.size() == 0, "bus_left", 64'(exp_bus.size()), 64'h0);
    check(exp_ack.size() == 0, "ack_left", 64'(exp_ack.size()), 64'h0);
    check(exp_grant.size() == 0, "grant_left", 64'(exp_grant.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
